// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
// Select codes map directly onto the 4:1 mux select pins {sel1,sel2}.
package mux_arb_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam logic [1:0] SEL_I0 = 2'd0;
    localparam logic [1:0] SEL_I1 = 2'd1;
    localparam logic [1:0] SEL_I2 = 2'd2;
    localparam logic [1:0] SEL_I3 = 2'd3;

    function automatic logic [NUM_REQ-1:0] onehot_from_idx(input logic [1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin search: first set request at or after start, wrapping.
// Shared by the arbiter for both idle pickup and release-time handover.
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         start,
    output logic               found,
    output logic [1:0]         idx
);

    // Scan farthest-to-nearest so the nearest hit is the one that sticks.
    always_comb begin
        found = 1'b0;
        idx   = start;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[start + 2'(i)]) begin
                found = 1'b1;
                idx   = start + 2'(i);
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner selection for a shared 4:1 mux, with a MAX_HOLD-cycle quantum.
// All outputs are registered; sel keeps the last owner while idle so y never glitches.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               sel1,
    output logic               sel2,
    output logic               valid
);

    localparam int CNT_W = $clog2(MAX_HOLD) + 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_e         state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [1:0]         sel_q;
    logic               valid_q;
    logic [CNT_W-1:0]   hold_cnt_q;
    logic [CNT_W-1:0]   hold_cnt_d;
    logic [1:0]         last_q;

    logic [1:0] pick_start;
    logic       pick_found;
    logic [1:0] pick_idx;
    logic       rel_now;

    // While granted, sel_q is the owner; searching from owner+1 lets it win again
    // only when nobody else is asking.
    assign pick_start = ((state_q == GRANT) ? sel_q : last_q) + 2'd1;
    assign rel_now    = !req[sel_q] || (hold_cnt_q == HOLD_LAST);
    assign hold_cnt_d = hold_cnt_q + CNT_W'(1);

    rr_pick4 u_pick (
        .req   (req),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            sel_q      <= SEL_I0;
            valid_q    <= 1'b0;
            hold_cnt_q <= '0;
            last_q     <= SEL_I3;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        state_q    <= GRANT;
                        grant_q    <= onehot_from_idx(pick_idx);
                        sel_q      <= pick_idx;
                        valid_q    <= 1'b1;
                        hold_cnt_q <= '0;
                    end
                end
                GRANT: begin
                    if (rel_now) begin
                        last_q     <= sel_q;
                        hold_cnt_q <= '0;
                        if (pick_found) begin
                            grant_q <= onehot_from_idx(pick_idx);
                            sel_q   <= pick_idx;
                        end else begin
                            state_q <= IDLE;
                            grant_q <= '0;
                            valid_q <= 1'b0;
                        end
                    end else begin
                        hold_cnt_q <= hold_cnt_d;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    grant_q    <= '0;
                    valid_q    <= 1'b0;
                    hold_cnt_q <= '0;
                end
            endcase
        end
    end

    assign grant = grant_q;
    assign sel1  = sel_q[1];
    assign sel2  = sel_q[0];
    assign valid = valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed and randomised bench for mux_rr_arbiter with a behavioural scoreboard.
module tb_mux_rr_arbiter;

    localparam int MAX_HOLD = 4;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] sel;
        logic       valid;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] grant;
    logic       sel1, sel2, valid;

    int checks = 0;
    int errors = 0;

    exp_t sb[$];

    int m_state = 0;
    int m_owner = 0;
    int m_last  = 3;
    int m_hold  = 0;
    int m_sel   = 0;

    mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .grant (grant),
        .sel1  (sel1),
        .sel2  (sel2),
        .valid (valid)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] g, input logic [1:0] s, input logic v);
        check({tag, "_grant"}, {4'b0, grant}, {4'b0, g});
        check({tag, "_sel"}, {6'b0, sel1, sel2}, {6'b0, s});
        check({tag, "_valid"}, {7'b0, valid}, {7'b0, v});
    endtask

    function automatic int search(input logic [3:0] r, input int start);
        for (int i = 0; i < 4; i++) begin
            if (r[(start + i) % 4]) return (start + i) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_state = 0; m_owner = 0; m_last = 3; m_hold = 0; m_sel = 0;
        sb.delete();
    endtask

    task automatic model_next(input logic [3:0] v);
        int p;
        if (m_state == 0) begin
            p = search(v, (m_last + 1) % 4);
            if (p >= 0) begin
                m_state = 1; m_owner = p; m_sel = p; m_hold = 0;
            end
        end else if (!v[m_owner] || m_hold == MAX_HOLD - 1) begin
            m_last = m_owner;
            m_hold = 0;
            p = search(v, (m_owner + 1) % 4);
            if (p >= 0) begin
                m_owner = p; m_sel = p;
            end else begin
                m_state = 0;
            end
        end else begin
            m_hold++;
        end
    endtask

    task automatic step(input logic [3:0] v);
        exp_t e, got;
        req = v;
        model_next(v);
        e.grant = (m_state == 1) ? (4'b0001 << m_owner) : 4'b0000;
        e.sel   = 2'(m_sel);
        e.valid = (m_state == 1);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 8'h01, 8'h00);
        end else begin
            e = sb.pop_front();
            got.grant = grant;
            got.sel   = {sel1, sel2};
            got.valid = valid;
            check("sb", {1'b0, got}, {1'b0, e});
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 4'b0000;
        #2;
        check_out("rst", 4'b0000, 2'b00, 1'b0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] v, cur_g, run_g;
        int run_len, max_wait;
        int wait_c[4];

        do_reset();

        // Single requester pickup and release to idle.
        step(4'b0001);
        check_out("t1_grant", 4'b0001, 2'b00, 1'b1);
        step(4'b0001);
        step(4'b0000);
        check_out("t1_idle", 4'b0000, 2'b00, 1'b0);

        // Full contention: quantum rotation with no bubbles.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(4'b1111);
            check_out("t2_rot", 4'b0001 << (i / 4), 2'(i / 4), 1'b1);
        end
        step(4'b0000);

        // Lone requester re-granted at quantum expiry without a gap.
        for (int i = 0; i < 10; i++) begin
            step(4'b0100);
            check_out("t3_hold", 4'b0100, 2'b10, 1'b1);
        end

        // Owner drops mid-quantum while req3 rises: direct handover.
        step(4'b0000);
        step(4'b0010);
        check_out("t4_own1", 4'b0010, 2'b01, 1'b1);
        step(4'b1000);
        check_out("t4_hand", 4'b1000, 2'b11, 1'b1);

        // Asynchronous reset mid-grant, pointer back to 3.
        step(4'b0100);
        check_out("t5_pre", 4'b0100, 2'b10, 1'b1);
        #2;
        reset = 1'b1;
        req   = 4'b0000;
        #1;
        check_out("t5_async", 4'b0000, 2'b00, 1'b0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step(4'b1111);
        check_out("t5_first", 4'b0001, 2'b00, 1'b1);
        step(4'b0000);

        // Random traffic: owners drop at random, waiting requesters stay asserted.
        v = 4'b0000;
        run_g = 4'b0000;
        run_len = 0;
        for (int k = 0; k < 4; k++) wait_c[k] = 0;
        for (int n = 0; n < 2000; n++) begin
            cur_g = grant;
            for (int k = 0; k < 4; k++) begin
                if (!v[k]) v[k] = 1'($urandom_range(0, 1));
                else if (cur_g[k]) v[k] = ($urandom_range(0, 3) != 0);
            end
            max_wait = 0;
            for (int k = 0; k < 4; k++) begin
                if (v[k] && !cur_g[k]) wait_c[k]++;
                else wait_c[k] = 0;
                if (wait_c[k] > max_wait) max_wait = wait_c[k];
            end
            if (cur_g != 4'b0000 && (v & ~cur_g) != 4'b0000) begin
                run_len = (cur_g == run_g) ? run_len + 1 : 1;
                run_g = cur_g;
            end else begin
                run_len = 0;
                run_g = 4'b0000;
            end
            check("rnd_wait", 8'(max_wait <= 3 * MAX_HOLD + 1), 8'h01);
            check("rnd_hold", 8'(run_len <= MAX_HOLD), 8'h01);
            step(v);
            check("rnd_onehot", 8'($onehot0(grant)), 8'h01);
            if (valid) check("rnd_selidx", {6'b0, sel1, sel2}, 8'($clog2(grant)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares the 4:1 mux (inputs i0..i3, selects sel1/sel2, output y) between four requesters.
- Registers a one-hot grant and drives sel1/sel2 so the granted input appears on y.
- Limits each ownership to a MAX_HOLD-cycle quantum, so one requester cannot starve the others.
- Sits directly in front of the mux: sel1/sel2 connect straight to the mux select pins.

Parameters:
- MAX_HOLD, 4: maximum consecutive cycles one requester may own the mux. Legal range 1..256.
- CNT_W, $clog2(MAX_HOLD)+1: width of the hold counter. Derived; never overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  4  req[k] high = requester k wants mux input ik routed to y.
- grant  output  4  one-hot registered grant; all zero when idle.
- sel1  output  1  mux select MSB.
- sel2  output  1  mux select LSB. {sel1,sel2} = index of the owner (00→i0, 01→i1, 10→i2, 11→i3).
- valid  output  1  high while grant is non-zero, i.e. y carries a granted source.

Behaviour:
- Reset, asynchronous, all state forced immediately:
  - grant=0000, sel1=0, sel2=0, valid=0.
  - FSM=IDLE, hold_cnt=0.
  - last pointer=3, so req0 has highest priority first.
- All outputs are registered. No combinational path from req to any output.
- States:
  - IDLE: no owner.
    - If req!=0, pick the first set bit searching (last+1) mod 4 upward with wrap.
    - Next edge: grant=onehot(pick), {sel1,sel2}=pick, valid=1, hold_cnt=0, go to GRANT.
    - Latency from req rising to grant: exactly 1 clock.
  - GRANT: owner o.
    - Continue if req[o]=1 and hold_cnt<MAX_HOLD-1; hold_cnt increments each cycle.
    - Release if req[o]=0, or hold_cnt==MAX_HOLD-1 (owner has had MAX_HOLD cycles of grant).
- On release:
  - last<=o.
  - Re-arbitrate in the same cycle over req with req[o] included, search starting at o+1.
  - If any requester wins, go to GRANT with the new owner at the next edge, with no idle bubble (back-to-back handover). hold_cnt restarts at 0.
  - If req is all zero (or req[o] dropped and nothing else pending), go to IDLE: grant=0000, valid=0.
- sel1/sel2 in IDLE keep the last owner's value, so the mux output stays glitch-free. Consumers qualify y with valid.
- Quantum expiry with only o still requesting: the search wraps back to o, so o is re-granted with no gap. grant stays constant and hold_cnt resets to 0.
- req[o] dropping mid-quantum: release at the next edge; unused cycles are forfeited.
- MAX_HOLD=1: every owner is released after 1 cycle, giving strict round-robin rotation each cycle.
- Bits of req other than the owner's are ignored while in GRANT, except at the release cycle.
- Reset asserted mid-grant: immediate return to reset values. The pointer returns to 3.
- Invariant: grant is always one-hot or zero, and {sel1,sel2} equals the index of the set grant bit whenever valid=1.

Decomposition:
- Package mux_arb_pkg:
  - NUM_REQ=4.
  - State enum {IDLE, GRANT}.
  - 2-bit select codes SEL_I0..SEL_I3.
  - onehot-from-index function.
- Sub-module rr_pick4: purely combinational.
  - Inputs: req[3:0], start[1:0].
  - Outputs: found, idx[1:0].
  - Function: first set bit at or after start, with wrap.
  - Instantiated once by the arbiter, used both in IDLE and at release.

Test Plan:
1. Reset then req=0001: grant=0001, sel=00, valid=1 one cycle later. Drop req after 2 cycles: return to IDLE, grant=0000, sel stays 00.
2. MAX_HOLD=4, req=1111 held for 16 cycles: grant rotates 0001,0010,0100,1000, four cycles each, with no idle cycle between owners. sel follows 00,01,10,11.
3. req=0100 held alone beyond 4 cycles: grant stays 0100 continuously, valid never drops, hold_cnt wraps to 0 every 4 cycles.
4. Owner 1 granted, req=0010→0000 mid-quantum while req[3] rises in the same cycle: next edge grant=1000, sel=11, no bubble.
5. Assert reset during grant 0100 (async, mid-cycle): outputs go to 0000/00/0 immediately. After release, req=1111 grants 0001 first.
6. Randomised req for 2000 cycles with a scoreboard checking:
   - one-hot grant;
   - {sel1,sel2} matches the grant index;
   - no owner holds longer than MAX_HOLD cycles while others request;
   - every steady requester is granted within 3*MAX_HOLD+1 cycles.
